hit_lane_packer: RTL

//  Collects single sample hits (position, depth, colour) from the sample-test stage and packs them into the
//  4-lane hit bus consumed by the z-buffer: hit_R18S/_1/_2/_3, color_R18U/_1/_2/_3, hit_valid_R18H/_1/_2/_3.
//  It is the transmitter end of that bus: oldest hit in lane 0, valids pulse for one cycle, no downstream stall.

---
 rtl/hit_lane_packer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/hit_lane_packer.sv
// Packs single sample hits into the 4-lane z-buffer hit bus; oldest hit in lane 0.
// Batches leave when full, after an idle timeout, or on an end-of-frame flush.
module hit_lane_packer #(
    parameter int SIGFIG  = 24,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIGFIG*AXIS-1:0]   hit_in_S,
    input  logic [SIGFIG*COLORS-1:0] color_in_U,
    input  logic                     hit_valid_in_H,
    output logic                     hit_ready_H,
    input  logic                     flush_H,
    output logic                     flush_done_H,
    output logic [SIGFIG*AXIS-1:0]   hit_R18S,
    output logic [SIGFIG*AXIS-1:0]   hit_R18S_1,
    output logic [SIGFIG*AXIS-1:0]   hit_R18S_2,
    output logic [SIGFIG*AXIS-1:0]   hit_R18S_3,
    output logic [SIGFIG*COLORS-1:0] color_R18U,
    output logic [SIGFIG*COLORS-1:0] color_R18U_1,
    output logic [SIGFIG*COLORS-1:0] color_R18U_2,
    output logic [SIGFIG*COLORS-1:0] color_R18U_3,
    output logic                     hit_valid_R18H,
    output logic                     hit_valid_R18H_1,
    output logic                     hit_valid_R18H_2,
    output logic                     hit_valid_R18H_3,
    output logic [31:0]              frag_count_U
);
    localparam int HW = SIGFIG * AXIS;
    localparam int CW = SIGFIG * COLORS;
    localparam int IW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {FILL, FLUSH, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt, n;
    logic [IW-1:0] idle, idle_nxt;
    logic          accept, emit, done_nxt;
    logic [HW-1:0] slot_hit [4];
    logic [CW-1:0] slot_col [4];
    logic [HW-1:0] wr_hit [4];
    logic [CW-1:0] wr_col [4];
    logic [HW-1:0] lane_hit [4];
    logic [CW-1:0] lane_col [4];
    logic [HW-1:0] lane_hit_nxt [4];
    logic [CW-1:0] lane_col_nxt [4];
    logic [3:0]    lane_valid, lane_valid_nxt;
    logic          done_q;
    logic [31:0]   frag_q;

    // Handshake: a hit transfers on a cycle where hit_valid_in_H and hit_ready_H are both high;
    // ready is high only in FILL and out of reset. The lane bus has no back-pressure.
    assign hit_ready_H = rst && (state == FILL);
    assign accept      = hit_valid_in_H && hit_ready_H;
    assign n           = cnt + {2'b00, accept};

    always_comb begin
        wr_hit    = slot_hit;
        wr_col    = slot_col;
        state_nxt = state;
        cnt_nxt   = cnt;
        idle_nxt  = idle;
        emit      = 1'b0;
        done_nxt  = 1'b0;
        if (accept) begin
            wr_hit[cnt[1:0]] = hit_in_S;
            wr_col[cnt[1:0]] = color_in_U;
        end
        case (state)
            FILL: begin
                if (n == 3'd4) emit = 1'b1;
                if (flush_H && (n != 3'd0)) emit = 1'b1;
                if (!accept && (cnt != 3'd0) && (idle == IW'(TIMEOUT - 1))) emit = 1'b1;
                if (flush_H) begin
                    if (n != 3'd0) begin
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end
                end
                cnt_nxt = emit ? 3'd0 : n;
                if (accept || emit) idle_nxt = '0;
                else if (cnt != 3'd0) idle_nxt = idle + IW'(1);
            end
            FLUSH: begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
            end
            DONE:    state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
        // Lanes 0..n-1 carry the batch; unused lanes are forced to zero.
        for (int i = 0; i < 4; i++) begin
            lane_valid_nxt[i] = emit && (3'(i) < n);
            lane_hit_nxt[i]   = lane_valid_nxt[i] ? wr_hit[i] : '0;
            lane_col_nxt[i]   = lane_valid_nxt[i] ? wr_col[i] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FILL;
            cnt        <= 3'd0;
            idle       <= '0;
            lane_valid <= 4'b0000;
            done_q     <= 1'b0;
            frag_q     <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                slot_hit[i] <= '0;
                slot_col[i] <= '0;
                lane_hit[i] <= '0;
                lane_col[i] <= '0;
            end
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idle       <= idle_nxt;
            lane_valid <= lane_valid_nxt;
            done_q     <= done_nxt;
            frag_q     <= frag_q + 32'(emit ? n : 3'd0);
            slot_hit   <= wr_hit;
            slot_col   <= wr_col;
            lane_hit   <= lane_hit_nxt;
            lane_col   <= lane_col_nxt;
        end
    end

    assign hit_R18S         = lane_hit[0];
    assign hit_R18S_1       = lane_hit[1];
    assign hit_R18S_2       = lane_hit[2];
    assign hit_R18S_3       = lane_hit[3];
    assign color_R18U       = lane_col[0];
    assign color_R18U_1     = lane_col[1];
    assign color_R18U_2     = lane_col[2];
    assign color_R18U_3     = lane_col[3];
    assign hit_valid_R18H   = lane_valid[0];
    assign hit_valid_R18H_1 = lane_valid[1];
    assign hit_valid_R18H_2 = lane_valid[2];
    assign hit_valid_R18H_3 = lane_valid[3];
    assign flush_done_H     = done_q;
    assign frag_count_U     = frag_q;
endmodule
